// File: rtl/control_sequencer_if.sv
// Control bundle between the instruction sequencer and the ALU datapath.
// The sequencer uses the master side; the datapath (or a bench) uses the slave side.
interface control_sequencer_if;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [2:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Write;
  logic        Mem_CS;
  logic        Mem_WR;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic [2:0]  SC;
  logic        Halted;

  modport master (
    input  IROut, Flags,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
           ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Write, Mem_CS, Mem_WR, MuxASel, MuxBSel, MuxCSel, SC, Halted
  );

  modport slave (
    output IROut, Flags,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
           ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Write, Mem_CS, Mem_WR, MuxASel, MuxBSel, MuxCSel, SC, Halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Three-phase fetch/fetch/execute sequencer with an absorbing HALT state.
// Control outputs decode from the sequence state, IROut and (for BNE) the Z flag.
module control_sequencer #(
  parameter logic [2:0] FS_LOAD = 3'b010,
  parameter logic [2:0] FS_INC  = 3'b001,
  parameter logic [4:0] ALU_ADD = 5'b10100
) (
  input  logic                 Clock,
  input  logic                 Reset,
  control_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    HALT = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic        halted_q;
  logic [3:0]  opcode;
  logic [3:0]  rd_sel;
  logic [1:0]  rs1, rs2;
  logic        unused_flags;

  assign opcode       = bus.IROut[15:12];
  assign rs1          = bus.IROut[9:8];
  assign rs2          = bus.IROut[7:6];
  assign rd_sel       = 4'b1000 >> bus.IROut[11:10];
  assign unused_flags = ^bus.Flags[2:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      T0:      state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = (opcode == 4'hF) ? HALT : T0;
      HALT:    state_d = HALT;
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
    end
  end

  assign bus.SC     = state_q;
  assign bus.Halted = halted_q;

  // Reset overrides the decode so no register or memory write escapes during a reset cycle.
  always_comb begin
    bus.RF_OutASel  = '0;
    bus.RF_OutBSel  = '0;
    bus.RF_FunSel   = '0;
    bus.RF_RegSel   = '0;
    bus.RF_ScrSel   = '0;
    bus.ALU_FunSel  = '0;
    bus.ALU_WF      = 1'b0;
    bus.ARF_OutCSel = '0;
    bus.ARF_OutDSel = '0;
    bus.ARF_FunSel  = '0;
    bus.ARF_RegSel  = '0;
    bus.IR_LH       = 1'b0;
    bus.IR_Write    = 1'b0;
    bus.Mem_CS      = 1'b1;
    bus.Mem_WR      = 1'b0;
    bus.MuxASel     = '0;
    bus.MuxBSel     = '0;
    bus.MuxCSel     = 1'b0;
    if (Reset) begin
      case (state_q)
        T0, T1: begin
          bus.ARF_OutDSel = 2'b00;
          bus.Mem_CS      = 1'b0;
          bus.IR_Write    = 1'b1;
          bus.IR_LH       = (state_q == T1);
          bus.ARF_RegSel  = 3'b100;
          bus.ARF_FunSel  = FS_INC;
        end
        T2: begin
          case (opcode)
            4'h1: begin
              bus.MuxASel   = 2'b11;
              bus.RF_FunSel = FS_LOAD;
              bus.RF_RegSel = rd_sel;
            end
            4'h2: begin
              bus.RF_OutASel = {1'b0, rs1};
              bus.RF_OutBSel = {1'b0, rs2};
              bus.ALU_FunSel = ALU_ADD;
              bus.ALU_WF     = 1'b1;
              bus.MuxASel    = 2'b00;
              bus.RF_FunSel  = FS_LOAD;
              bus.RF_RegSel  = rd_sel;
            end
            4'h3: begin
              bus.ARF_OutDSel = 2'b10;
              bus.Mem_CS      = 1'b0;
              bus.MuxASel     = 2'b10;
              bus.RF_FunSel   = FS_LOAD;
              bus.RF_RegSel   = rd_sel;
            end
            4'h4: begin
              bus.ARF_OutDSel = 2'b10;
              bus.RF_OutASel  = {1'b0, rs1};
              bus.ALU_FunSel  = 5'b10000;
              bus.MuxCSel     = 1'b0;
              bus.Mem_CS      = 1'b0;
              bus.Mem_WR      = 1'b1;
            end
            4'h5: begin
              bus.MuxBSel    = 2'b11;
              bus.ARF_RegSel = 3'b100;
              bus.ARF_FunSel = FS_LOAD;
            end
            4'h6: begin
              if (!bus.Flags[3]) begin
                bus.MuxBSel    = 2'b11;
                bus.ARF_RegSel = 3'b100;
                bus.ARF_FunSel = FS_LOAD;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomized checks of control_sequencer against a phase-counting reference model.
module tb_control_sequencer;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [4:0] ALU_ADD = 5'b10100;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  control_sequencer_if bus ();

  control_sequencer #(
    .FS_LOAD (FS_LOAD),
    .FS_INC  (FS_INC),
    .ALU_ADD (ALU_ADD)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int nvec = 0;
  int nerr = 0;

  // Model: position within the current instruction (0..2) and whether HLT retired.
  int m_phase = 0;
  bit m_halt  = 1'b0;

  logic [41:0] obs_ctrl;
  assign obs_ctrl = {bus.RF_OutASel, bus.RF_OutBSel, bus.RF_FunSel, bus.RF_RegSel,
                     bus.RF_ScrSel, bus.ALU_FunSel, bus.ALU_WF, bus.ARF_OutCSel,
                     bus.ARF_OutDSel, bus.ARF_FunSel, bus.ARF_RegSel, bus.IR_LH,
                     bus.IR_Write, bus.Mem_CS, bus.Mem_WR, bus.MuxASel, bus.MuxBSel,
                     bus.MuxCSel};

  function automatic logic [41:0] exp_ctrl(bit in_reset, bit halt, int phase,
                                            logic [15:0] ir, logic [3:0] fl);
    logic [2:0] oa, ob, rfs, afs, ars;
    logic [3:0] rrs, scr;
    logic [4:0] alu;
    logic       wf, ilh, iw, cs, wr, mc;
    logic [1:0] oc, od, ma, mb;
    int         op, rd;
    oa = 0; ob = 0; rfs = 0; afs = 0; ars = 0; rrs = 0; scr = 0; alu = 0;
    wf = 0; ilh = 0; iw = 0; cs = 1; wr = 0; mc = 0; oc = 0; od = 0; ma = 0; mb = 0;
    op = int'(ir[15:12]);
    rd = int'(ir[11:10]);
    if (!in_reset && !halt) begin
      if (phase < 2) begin
        cs = 0; iw = 1; ilh = (phase == 1); ars = 3'b100; afs = FS_INC;
      end else if (op == 1) begin
        ma = 2'b11; rfs = FS_LOAD; rrs = 4'(1 << (3 - rd));
      end else if (op == 2) begin
        oa = 3'(int'(ir[9:8])); ob = 3'(int'(ir[7:6])); alu = ALU_ADD; wf = 1;
        rfs = FS_LOAD; rrs = 4'(1 << (3 - rd));
      end else if (op == 3) begin
        od = 2'b10; cs = 0; ma = 2'b10; rfs = FS_LOAD; rrs = 4'(1 << (3 - rd));
      end else if (op == 4) begin
        od = 2'b10; oa = 3'(int'(ir[9:8])); alu = 5'b10000; cs = 0; wr = 1;
      end else if (op == 5 || (op == 6 && fl[3] == 1'b0)) begin
        mb = 2'b11; ars = 3'b100; afs = FS_LOAD;
      end
    end
    return {oa, ob, rfs, rrs, scr, alu, wf, oc, od, afs, ars, ilh, iw, cs, wr, ma, mb, mc};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] cur_ir;

  // Drive one cycle's inputs and compare everything against the model.
  task automatic apply(string tag, logic rst, logic [15:0] ir, logic [3:0] fl);
    Reset = rst; bus.IROut = ir; bus.Flags = fl; cur_ir = ir;
    #1;
    chk({tag, ".ctrl"}, 64'(obs_ctrl), 64'(exp_ctrl(!rst, m_halt, m_phase, ir, fl)));
    chk({tag, ".SC"}, 64'(bus.SC), 64'(m_halt ? 7 : m_phase));
    chk({tag, ".Halted"}, 64'(bus.Halted), 64'(m_halt));
  endtask

  task automatic step();
    @(posedge Clock);
    if (!Reset) begin
      m_phase = 0; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_phase == 2 && cur_ir[15:12] == 4'hF) m_halt = 1'b1;
      else m_phase = (m_phase + 1) % 3;
    end
    #1;
  endtask

  initial begin
    logic [15:0] rir;
    logic        rrst;
    // First reset cycle: state is unknown, only the forced defaults are checked.
    Reset = 1'b0; bus.IROut = '0; bus.Flags = '0; cur_ir = '0;
    #1;
    chk("rst0.ctrl", 64'(obs_ctrl), 64'(exp_ctrl(1'b1, 1'b0, 0, 16'h0000, 4'h0)));
    step();
    apply("rst1", 1'b0, 16'h0000, 4'h0);
    step();

    apply("movl.T0", 1'b1, 16'h1455, 4'h0);
    chk("T0.SC", 64'(bus.SC), 64'd0);
    chk("T0.IR_Write", 64'(bus.IR_Write), 64'd1);
    chk("T0.IR_LH", 64'(bus.IR_LH), 64'd0);
    chk("T0.ARF_FunSel", 64'(bus.ARF_FunSel), 64'(FS_INC));
    chk("T0.ARF_RegSel", 64'(bus.ARF_RegSel), 64'd4);
    step();
    apply("movl.T1", 1'b1, 16'h1455, 4'h0);
    chk("T1.SC", 64'(bus.SC), 64'd1);
    chk("T1.IR_Write", 64'(bus.IR_Write), 64'd1);
    chk("T1.IR_LH", 64'(bus.IR_LH), 64'd1);
    chk("T1.ARF_FunSel", 64'(bus.ARF_FunSel), 64'(FS_INC));
    step();
    apply("movl.T2", 1'b1, 16'h1455, 4'h0);
    chk("movl.SC", 64'(bus.SC), 64'd2);
    chk("movl.MuxASel", 64'(bus.MuxASel), 64'd3);
    chk("movl.RF_RegSel", 64'(bus.RF_RegSel), 64'h4);
    chk("movl.RF_FunSel", 64'(bus.RF_FunSel), 64'(FS_LOAD));
    step();

    apply("add.T0", 1'b1, 16'h2E40, 4'h0);
    chk("add.T0.SC", 64'(bus.SC), 64'd0);
    step();
    apply("add.T1", 1'b1, 16'h2E40, 4'h0);
    step();
    apply("add.T2", 1'b1, 16'h2E40, 4'h0);
    chk("add.RF_OutASel", 64'(bus.RF_OutASel), 64'd2);
    chk("add.RF_OutBSel", 64'(bus.RF_OutBSel), 64'd1);
    chk("add.ALU_FunSel", 64'(bus.ALU_FunSel), 64'h14);
    chk("add.ALU_WF", 64'(bus.ALU_WF), 64'd1);
    chk("add.RF_RegSel", 64'(bus.RF_RegSel), 64'h1);
    step();

    for (int k = 0; k < 2; k++) begin
      apply("bne.T0", 1'b1, 16'h6020, (k == 0) ? 4'b1000 : 4'b0000);
      step();
      apply("bne.T1", 1'b1, 16'h6020, (k == 0) ? 4'b1000 : 4'b0000);
      step();
      apply("bne.T2", 1'b1, 16'h6020, (k == 0) ? 4'b1000 : 4'b0000);
      if (k == 0) begin
        chk("bne.taken_z.ARF_RegSel", 64'(bus.ARF_RegSel), 64'd0);
      end else begin
        chk("bne.nz.ARF_RegSel", 64'(bus.ARF_RegSel), 64'd4);
        chk("bne.nz.MuxBSel", 64'(bus.MuxBSel), 64'd3);
      end
      step();
    end

    // Reset in the middle of a fetch.
    apply("mid.T0", 1'b1, 16'h1455, 4'h0);
    step();
    apply("mid.T1rst", 1'b0, 16'h1455, 4'h0);
    chk("mid.IR_Write", 64'(bus.IR_Write), 64'd0);
    step();
    apply("mid.after", 1'b1, 16'h1455, 4'h0);
    chk("mid.SC", 64'(bus.SC), 64'd0);
    step();
    apply("mid.T1", 1'b1, 16'h0000, 4'h0);
    step();
    apply("mid.T2", 1'b1, 16'h0000, 4'h0);
    step();

    apply("hlt.T0", 1'b1, 16'hF000, 4'h0);
    step();
    apply("hlt.T1", 1'b1, 16'hF000, 4'h0);
    step();
    apply("hlt.T2", 1'b1, 16'hF000, 4'h0);
    step();
    for (int k = 0; k < 10; k++) begin
      apply("halt", 1'b1, 16'($urandom), 4'($urandom));
      chk("halt.SC", 64'(bus.SC), 64'd7);
      chk("halt.Halted", 64'(bus.Halted), 64'd1);
      step();
    end
    apply("halt.rst", 1'b0, 16'h0000, 4'h0);
    step();
    apply("halt.exit", 1'b1, 16'h0000, 4'h0);
    chk("halt.exit.SC", 64'(bus.SC), 64'd0);
    chk("halt.exit.Halted", 64'(bus.Halted), 64'd0);
    step();

    for (int k = 0; k < 600; k++) begin
      rir  = 16'($urandom);
      if (rir[15:12] == 4'hF && $urandom_range(0, 2) != 0) rir[15:12] = 4'h5;
      rrst = ($urandom_range(0, 39) != 0);
      apply("rand", rrst, rir, 4'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
